// File: rtl/discrim_sequencer_if.sv
// discrim_sequencer_if
// Groups the run-control and result signals exchanged between the
// discriminator run controller and its environment.
//   start, auto_en, abort   run requests and cancel
//   meas_len                measurement window length in cycles
//   amp_done, freq_done     analyser completion levels
//   signal_type             raw classification from the discriminator
//   meas_trigger            one-cycle pulse opening a measurement
//   judge_trigger           two-cycle pulse requesting classification
//   busy                    controller is not idle
//   type_valid, last_type   per-run result strobe and value
//   type_out, type_locked   confirmed type and its validity
//   timeout_err             sticky flag: last run timed out
// The sequencer uses the slave modport; the environment uses master.
interface discrim_sequencer_if #(
    parameter int WIN_W = 24
);
    logic             start;
    logic             auto_en;
    logic             abort;
    logic [WIN_W-1:0] meas_len;
    logic             amp_done;
    logic             freq_done;
    logic [2:0]       signal_type;
    logic             meas_trigger;
    logic             judge_trigger;
    logic             busy;
    logic             type_valid;
    logic [2:0]       last_type;
    logic [2:0]       type_out;
    logic             type_locked;
    logic             timeout_err;

    modport master (
        output start, auto_en, abort, meas_len, amp_done, freq_done, signal_type,
        input  meas_trigger, judge_trigger, busy, type_valid, last_type,
               type_out, type_locked, timeout_err
    );

    modport slave (
        input  start, auto_en, abort, meas_len, amp_done, freq_done, signal_type,
        output meas_trigger, judge_trigger, busy, type_valid, last_type,
               type_out, type_locked, timeout_err
    );
endinterface

// File: rtl/discrim_sequencer.sv
// discrim_sequencer
// Run controller for the signal discriminator: opens a measurement,
// times the window, waits for both analysers, requests a judgement and
// captures the resulting type. A type is published on type_out only
// after CONFIRM consecutive identical, non-NA results.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    discrim_sequencer_if.slave (run control in, triggers/results out)
// All outputs are registered; the pulse outputs are decoded from the
// next state so they line up with the state they belong to.
module discrim_sequencer #(
    parameter int WIN_W   = 24,
    parameter int TIMEOUT = 2_000_000,
    parameter int CONFIRM = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    discrim_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        MEAS_START,
        WINDOW,
        WAIT_DONE,
        JUDGE1,
        JUDGE2,
        SETTLE,
        CAPTURE
    } state_t;

    localparam logic [2:0]       TYPE_NA   = 3'b100;
    localparam logic [2:0]       CONFIRM_V = 3'(CONFIRM);
    localparam logic [WIN_W-1:0] TO_LAST   = WIN_W'(TIMEOUT - 1);

    state_t           state, next_state;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] to_cnt;
    logic [2:0]       cand;
    logic [2:0]       conf_cnt;
    logic [2:0]       next_cand;
    logic [2:0]       next_cnt;
    logic             both_done;
    logic             timeout_hit;
    logic             capture;

    logic             meas_trigger_q;
    logic             judge_trigger_q;
    logic             busy_q;
    logic             type_valid_q;
    logic [2:0]       last_type_q;
    logic [2:0]       type_out_q;
    logic             type_locked_q;
    logic             timeout_err_q;

    assign both_done   = bus.amp_done & bus.freq_done;
    // Completion wins over the timeout if both happen in the same cycle.
    assign timeout_hit = (state == WAIT_DONE) && !both_done && (to_cnt == TO_LAST) && !bus.abort;
    assign capture     = (state == CAPTURE) && !bus.abort;

    // Next-state logic; abort overrides every transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (bus.start || bus.auto_en) next_state = MEAS_START;
            MEAS_START: next_state = WINDOW;
            WINDOW:     if (win_cnt <= WIN_W'(1)) next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (both_done)
                    next_state = JUDGE1;
                else if (to_cnt == TO_LAST)
                    next_state = bus.auto_en ? MEAS_START : IDLE;
            end
            JUDGE1:     next_state = JUDGE2;
            JUDGE2:     next_state = SETTLE;
            SETTLE:     next_state = CAPTURE;
            CAPTURE:    next_state = bus.auto_en ? MEAS_START : IDLE;
            default:    next_state = IDLE;
        endcase
        if (bus.abort) next_state = IDLE;
    end

    // Confirmation candidate/count update for the result being captured.
    // NA clears the streak but keeps the candidate.
    always_comb begin
        next_cand = cand;
        next_cnt  = conf_cnt;
        if (bus.signal_type == TYPE_NA) begin
            next_cnt = 3'd0;
        end else if (bus.signal_type == cand) begin
            next_cnt = (conf_cnt >= CONFIRM_V) ? CONFIRM_V : conf_cnt + 3'd1;
        end else begin
            next_cand = bus.signal_type;
            next_cnt  = 3'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Window and timeout counters. The timeout counter runs only while
    // the FSM stays in WAIT_DONE and is cleared on any exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (bus.abort)
                win_cnt <= '0;
            else if (state == MEAS_START)
                win_cnt <= (bus.meas_len == '0) ? WIN_W'(1) : bus.meas_len;
            else if (state == WINDOW)
                win_cnt <= win_cnt - WIN_W'(1);

            if (state == WAIT_DONE && next_state == WAIT_DONE)
                to_cnt <= to_cnt + WIN_W'(1);
            else
                to_cnt <= '0;
        end
    end

    // Registered strobes and status decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_trigger_q  <= 1'b0;
            judge_trigger_q <= 1'b0;
            busy_q          <= 1'b0;
            type_valid_q    <= 1'b0;
            last_type_q     <= TYPE_NA;
        end else begin
            meas_trigger_q  <= (next_state == MEAS_START);
            judge_trigger_q <= (next_state == JUDGE1) || (next_state == JUDGE2);
            busy_q          <= (next_state != IDLE);
            type_valid_q    <= capture;
            if (capture) last_type_q <= bus.signal_type;
        end
    end

    // Confirmation, lock and timeout flag. Abort and timeout drop the
    // lock but keep the last published type.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand          <= TYPE_NA;
            conf_cnt      <= 3'd0;
            type_out_q    <= TYPE_NA;
            type_locked_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else if (bus.abort) begin
            conf_cnt      <= 3'd0;
            type_locked_q <= 1'b0;
        end else if (timeout_hit) begin
            conf_cnt      <= 3'd0;
            type_locked_q <= 1'b0;
            timeout_err_q <= 1'b1;
        end else begin
            if (state == MEAS_START) timeout_err_q <= 1'b0;
            if (capture) begin
                cand     <= next_cand;
                conf_cnt <= next_cnt;
                if (next_cnt == CONFIRM_V) begin
                    type_out_q    <= next_cand;
                    type_locked_q <= 1'b1;
                end
            end
        end
    end

    assign bus.meas_trigger  = meas_trigger_q;
    assign bus.judge_trigger = judge_trigger_q;
    assign bus.busy          = busy_q;
    assign bus.type_valid    = type_valid_q;
    assign bus.last_type     = last_type_q;
    assign bus.type_out      = type_out_q;
    assign bus.type_locked   = type_locked_q;
    assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_discrim_sequencer.sv
// tb_discrim_sequencer
// Directed bench for discrim_sequencer (TIMEOUT shortened to 20).
// Expected per-run results are queued when a run is set up and popped
// whenever the DUT strobes type_valid; cycle profiles of the pulse
// outputs are compared against masks built from the run latency.
module tb_discrim_sequencer;

    typedef struct packed {
        logic [2:0] last;
        logic [2:0] out;
        logic       locked;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];

    discrim_sequencer_if #(.WIN_W(24)) bus ();

    discrim_sequencer #(
        .WIN_W   (24),
        .TIMEOUT (20),
        .CONFIRM (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global guard so the bench always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input logic [2:0] last, input logic [2:0] out, input logic locked);
        exp_t e;
        e.last   = last;
        e.out    = out;
        e.locked = locked;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        check_output("type_valid_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output("last_type", 64'(bus.last_type), 64'(e.last));
            check_output("type_out", 64'(bus.type_out), 64'(e.out));
            check_output("type_locked", 64'(bus.type_locked), 64'(e.locked));
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.type_valid === 1'b1) sb_check();
    endtask

    task automatic check_reset_values(input string phase);
        check_output({phase, "_meas_trigger"}, 64'(bus.meas_trigger), 64'd0);
        check_output({phase, "_judge_trigger"}, 64'(bus.judge_trigger), 64'd0);
        check_output({phase, "_busy"}, 64'(bus.busy), 64'd0);
        check_output({phase, "_type_valid"}, 64'(bus.type_valid), 64'd0);
        check_output({phase, "_last_type"}, 64'(bus.last_type), 64'h4);
        check_output({phase, "_type_out"}, 64'(bus.type_out), 64'h4);
        check_output({phase, "_type_locked"}, 64'(bus.type_locked), 64'd0);
        check_output({phase, "_timeout_err"}, 64'(bus.timeout_err), 64'd0);
    endtask

    function automatic logic [63:0] bits(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // One single-mode run: start sampled at edge 0, bit k of each mask
    // holds the output seen in cycle k.
    task automatic apply_stimulus(input int len, input logic [2:0] typ, input bit hold_start,
                                  input int ncyc, output logic [63:0] mt, output logic [63:0] jt,
                                  output logic [63:0] tv, output logic [63:0] bz,
                                  output logic [63:0] er);
        int leff;
        leff = (len == 0) ? 1 : len;
        mt = '0; jt = '0; tv = '0; bz = '0; er = '0;
        bus.meas_len    = 24'(len);
        bus.signal_type = typ;
        bus.start       = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            mt[k] = bus.meas_trigger;
            jt[k] = bus.judge_trigger;
            tv[k] = bus.type_valid;
            bz[k] = bus.busy;
            er[k] = bus.timeout_err;
            bus.start = hold_start && (k < leff + 7);
        end
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (bus.type_valid === 1'b1) seen = 1'b1;
        end
        check_output("type_valid_seen", 64'(seen), 64'd1);
    endtask

    task automatic auto_result(input logic [2:0] typ, input logic [2:0] out, input logic locked);
        bus.signal_type = typ;
        push_expect(typ, out, locked);
        wait_valid(60);
    endtask

    initial begin
        logic [63:0] mt, jt, tv, bz, er;
        int t1;
        bit judge_seen;

        rst_n           = 1'b1;
        bus.start       = 1'b0;
        bus.auto_en     = 1'b0;
        bus.abort       = 1'b0;
        bus.meas_len    = '0;
        bus.amp_done    = 1'b1;
        bus.freq_done   = 1'b1;
        bus.signal_type = 3'b100;
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_reset_values("post_reset");

        // Single run, L=4, result AM.
        push_expect(3'b001, 3'b100, 1'b0);
        apply_stimulus(4, 3'b001, 1'b0, 14, mt, jt, tv, bz, er);
        check_output("single_meas_mask", mt, bits(1, 1));
        check_output("single_judge_mask", jt, bits(7, 8));
        check_output("single_valid_mask", tv, bits(11, 11));
        check_output("single_busy_mask", bz, bits(1, 10));

        // meas_len = 0 behaves as a one-cycle window; NA result.
        push_expect(3'b100, 3'b100, 1'b0);
        apply_stimulus(0, 3'b100, 1'b0, 12, mt, jt, tv, bz, er);
        check_output("len0_meas_mask", mt, bits(1, 1));
        check_output("len0_judge_mask", jt, bits(4, 5));
        check_output("len0_valid_mask", tv, bits(8, 8));

        // start held high through the run must not queue a second run.
        push_expect(3'b101, 3'b100, 1'b0);
        apply_stimulus(3, 3'b101, 1'b1, 20, mt, jt, tv, bz, er);
        check_output("busy_start_meas_mask", mt, bits(1, 1));
        check_output("busy_start_valid_mask", tv, bits(10, 10));

        // Auto mode: lock on FSK, hold through one FM, switch after three FM.
        bus.meas_len = 24'd2;
        bus.auto_en  = 1'b1;
        auto_result(3'b110, 3'b100, 1'b0);
        t1 = cyc;
        auto_result(3'b110, 3'b100, 1'b0);
        check_output("auto_period", 64'(cyc - t1), 64'd8);
        auto_result(3'b110, 3'b110, 1'b1);
        auto_result(3'b010, 3'b110, 1'b1);
        auto_result(3'b010, 3'b110, 1'b1);
        bus.auto_en = 1'b0;
        auto_result(3'b010, 3'b010, 1'b1);
        check_output("auto_stop_busy", 64'(bus.busy), 64'd0);
        repeat (10) tick();
        check_output("auto_idle_busy", 64'(bus.busy), 64'd0);

        // Abort in cycle 30 of a 100-cycle window.
        bus.meas_len = 24'd100;
        bus.start    = 1'b1;
        judge_seen   = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int k = 2; k <= 30; k++) begin
            tick();
            if (bus.judge_trigger === 1'b1) judge_seen = 1'b1;
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_output("abort_busy", 64'(bus.busy), 64'd0);
        check_output("abort_meas_trigger", 64'(bus.meas_trigger), 64'd0);
        check_output("abort_type_out", 64'(bus.type_out), 64'h2);
        check_output("abort_type_locked", 64'(bus.type_locked), 64'd0);
        check_output("abort_last_type", 64'(bus.last_type), 64'h2);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.judge_trigger === 1'b1) judge_seen = 1'b1;
        end
        check_output("abort_no_judge", 64'(judge_seen), 64'd0);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_output("abort_start_idle", 64'(bus.busy), 64'd0);

        // NA breaks the streak without unlocking a new candidate.
        bus.meas_len = 24'd1;
        bus.auto_en  = 1'b1;
        auto_result(3'b111, 3'b010, 1'b0);
        auto_result(3'b100, 3'b010, 1'b0);
        auto_result(3'b111, 3'b010, 1'b0);
        auto_result(3'b111, 3'b010, 1'b0);
        bus.auto_en = 1'b0;
        auto_result(3'b111, 3'b111, 1'b1);
        repeat (3) tick();

        // Timeout: freq_done low, WAIT_DONE occupies cycles 4..23.
        bus.freq_done = 1'b0;
        apply_stimulus(2, 3'b001, 1'b0, 30, mt, jt, tv, bz, er);
        check_output("to_meas_mask", mt, bits(1, 1));
        check_output("to_judge_mask", jt, 64'd0);
        check_output("to_valid_mask", tv, 64'd0);
        check_output("to_busy_mask", bz, bits(1, 23));
        check_output("to_err_mask", er, bits(24, 30));
        check_output("to_type_locked", 64'(bus.type_locked), 64'd0);
        check_output("to_type_out", 64'(bus.type_out), 64'h7);

        // Next run clears the sticky timeout flag.
        bus.freq_done = 1'b1;
        push_expect(3'b001, 3'b111, 1'b0);
        apply_stimulus(2, 3'b001, 1'b0, 12, mt, jt, tv, bz, er);
        check_output("to_clear_err", er & ~64'h3, 64'd0);
        check_output("to_clear_valid_mask", tv, bits(9, 9));

        // Asynchronous reset during JUDGE1 (cycle 5 for L=2).
        bus.meas_len = 24'd2;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check_output("judge1_trigger", 64'(bus.judge_trigger), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrun_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        check_output("after_reset_busy", 64'(bus.busy), 64'd0);

        check_output("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
